ldpc_3gpp_enc_mm_seq: RTL and testbench
=======================================

Name: ldpc_3gpp_enc_mm_seq

Overview:
Initiator/sequencer that drives the write and read ports of the encoder single-port-RAM matrix multiplier (ldpc_3gpp_enc_mm_spram).
- Per block column: loads Zc/pDAT_W data words from an input stream into the multiplier.
- Then walks a list of Hb entries from an external Hb ROM. For each entry it issues one read cycle with correct irstart/irval/irstrb framing, keeping irHb stable across the cycle.
- Sits between the encoder top-level control/Hb ROM and the multiplier.

Parameters:
pADDR_W, 8, multiplier RAM address width; iused_zc must fit.
pHB_ADDR_W, 8, Hb ROM address width.
pHB_CNT_W, 5, width of the per-column Hb entry count.

Ports:
iclk  in  1  clock
ireset_n  in  1  asynchronous active-low reset
iclkena  in  1  clock enable; all state frozen when low
iused_zc  in  hb_zc_t  words per block (Zc/pDAT_W), ≥1, stable while obusy
istart  in  1  start one column job; ignored while obusy
ihb_base  in  pHB_ADDR_W  first Hb ROM address of this column, sampled at istart
ihb_cnt  in  pHB_CNT_W  number of Hb entries to process, sampled at istart
ival  in  1  input word valid
idat  in  dat_t  input word
ordy  out  1  sequencer accepts idat (LOAD state)
ohb_raddr  out  pHB_ADDR_W  Hb ROM address
ihb_rdat  in  mm_hb_value_t  Hb ROM data, 1-cycle read latency
owrite/owstart/owdat  out  1/1/dat_t  to multiplier iwrite/iwstart/iwdat
oread/orstart  out  1/1  to multiplier iread/irstart
orHb  out  mm_hb_value_t  to multiplier irHb
orval  out  1  to multiplier irval
orstrb  out  strb_t  to multiplier irstrb; sop/eop driven, other fields 0
obusy  out  1  job in progress
odone  out  1  one-cycle pulse at job end

Behaviour:
- Reset state:
  - FSM=IDLE.
  - All outputs 0: ordy, owrite, owstart, oread, orstart, orval, orstrb, obusy, odone, ohb_raddr, orHb, owdat.
- States: IDLE, LOAD, FETCH, RSTART, RVAL, RGAP, DONE.
- IDLE:
  - On istart, latch ihb_base, ihb_cnt and iused_zc-1.
  - Clear word counter wcnt and entry counter hcnt.
  - Go to LOAD. obusy=1 from the next cycle.
- LOAD:
  - ordy=1.
  - Each ival cycle: owrite=1, owdat=idat, wcnt++.
  - owstart=1 on the first accepted word only.
  - All outputs are combinational from ival/idat (no added latency); gaps with ival=0 are allowed.
  - After word iused_zc-1 is accepted: ihb_cnt==0 → DONE, otherwise → FETCH.
- FETCH:
  - Drive ohb_raddr=ihb_base+hcnt. Stay 1 cycle for ROM latency.
  - This also guarantees ≥1 idle cycle after the last owrite, so the multiplier's registered write lands before the first read.
- RSTART:
  - Register orHb<=ihb_rdat.
  - oread=1, orstart=1, orval=0.
- RVAL:
  - oread=1, orval=1, for exactly iused_zc cycles.
  - orstrb.sop on the first cycle, orstrb.eop on the last.
  - iused_zc==1 → sop and eop in the same cycle.
- RGAP:
  - One cycle, oread=0, orval=0; covers the multiplier upload pipeline.
  - orHb is held from RSTART through RGAP inclusive.
  - hcnt++. If hcnt==ihb_cnt-1 → DONE, else → FETCH.
- Read slot length is 1+iused_zc+1 cycles, plus 1 FETCH cycle per entry.
- DONE: odone=1 for one cycle, obusy=0 next, → IDLE.
- Interlocks: ordy=0 outside LOAD; ival outside LOAD is ignored. owrite and oread are never high in the same cycle.
- Counters: wcnt is pADDR_W wide and compares against latched iused_zc-1. Address computation ihb_base+hcnt wraps modulo 2^pHB_ADDR_W.
- iclkena=0: FSM, counters and all registered outputs hold. The combinational owrite is gated by iclkena.
- istart while obusy: ignored, with no effect on the running job.
- Asynchronous reset mid-job: immediate return to IDLE with all outputs 0. The multiplier contents are then undefined and a new job must reload.

Decomposition:
- Shared enc types package (already holding dat_t, strb_t, hb_zc_t, mm_hb_value_t) gains:
  - the FSM state enum ldpc_3gpp_enc_mm_seq_state_t;
  - the strb_t sop/eop field accessors, if not already present.
- No sub-module; single FSM plus counters. Multiplier instantiated only in the bench.

Test Plan:
- Zc words=4, ihb_cnt=1, wshift=1, bshift=0, left shift, data 0..3 → 4 owrite with owstart on the first. Read slot orstart, then 4 orval with sop/eop. Multiplier odat = 1,2,3,0; odone after RGAP.
- iused_zc=1, ihb_cnt=3 → three slots each with sop=eop on a single orval cycle. ohb_raddr = base, base+1, base+2; FETCH cycle between slots.
- ihb_cnt=0 → LOAD only, no oread, odone 1 cycle after last write.
- ival toggled 1-0-1-0 during LOAD with iclkena low for 3 random cycles → exactly iused_zc writes, no duplicate owstart, outputs frozen during clkena low.
- istart pulsed mid-RVAL → ignored; the running job finishes with the original entry count.
- ireset_n asserted during RVAL → all outputs 0 asynchronously. New istart after release runs a full correct job; scoreboard vs golden circshift model.

Source files
------------

// File: rtl/ldpc_3gpp_enc_mm_seq_pkg.sv
// Shared encoder types for the matrix-multiplier sequencer: data/strobe/Hb
// types, the sequencer state enum and strobe field helpers.
package ldpc_3gpp_enc_mm_seq_pkg;

  localparam int pDAT_W = 8;
  localparam int pZC_W  = 8;

  typedef logic [pDAT_W-1:0] dat_t;
  typedef logic [pZC_W-1:0]  hb_zc_t;

  typedef struct packed {
    logic sof;
    logic sop;
    logic eop;
    logic eof;
  } strb_t;

  typedef struct packed {
    logic       left;
    logic [3:0] bshift;
    logic [7:0] wshift;
  } mm_hb_value_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_RSTART,
    ST_RVAL,
    ST_RGAP,
    ST_DONE
  } ldpc_3gpp_enc_mm_seq_state_t;

  function automatic strb_t strb_make(input logic sop, input logic eop);
    strb_t s;
    s     = '0;
    s.sop = sop;
    s.eop = eop;
    return s;
  endfunction

  function automatic logic strb_sop(input strb_t s);
    return s.sop;
  endfunction

  function automatic logic strb_eop(input strb_t s);
    return s.eop;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_enc_mm_seq_if.sv
// Stream-in, Hb ROM and multiplier write/read bus of the sequencer.
// master = sequencer side, slave = surrounding logic (source, ROM, multiplier).
interface ldpc_3gpp_enc_mm_seq_if
  import ldpc_3gpp_enc_mm_seq_pkg::*;
#(
  parameter int pHB_ADDR_W = 8
) ();

  logic                  ival;
  dat_t                  idat;
  logic                  ordy;
  logic [pHB_ADDR_W-1:0] ohb_raddr;
  mm_hb_value_t          ihb_rdat;
  logic                  owrite;
  logic                  owstart;
  dat_t                  owdat;
  logic                  oread;
  logic                  orstart;
  mm_hb_value_t          orHb;
  logic                  orval;
  strb_t                 orstrb;

  modport master (
    input  ival, idat, ihb_rdat,
    output ordy, ohb_raddr, owrite, owstart, owdat,
           oread, orstart, orHb, orval, orstrb
  );

  modport slave (
    output ival, idat, ihb_rdat,
    input  ordy, ohb_raddr, owrite, owstart, owdat,
           oread, orstart, orHb, orval, orstrb
  );

endinterface

// File: rtl/ldpc_3gpp_enc_mm_seq.sv
// Column-job sequencer: loads Zc/pDAT_W words into the multiplier, then
// issues one framed read slot per Hb entry fetched from the Hb ROM.
module ldpc_3gpp_enc_mm_seq
  import ldpc_3gpp_enc_mm_seq_pkg::*;
#(
  parameter int pADDR_W    = 8,
  parameter int pHB_ADDR_W = 8,
  parameter int pHB_CNT_W  = 5
) (
  input  logic                  iclk,
  input  logic                  ireset_n,
  input  logic                  iclkena,
  input  hb_zc_t                iused_zc,
  input  logic                  istart,
  input  logic [pHB_ADDR_W-1:0] ihb_base,
  input  logic [pHB_CNT_W-1:0]  ihb_cnt,
  output logic                  obusy,
  output logic                  odone,
  ldpc_3gpp_enc_mm_seq_if.master bus
);

  ldpc_3gpp_enc_mm_seq_state_t r_state, w_next;

  logic [pHB_ADDR_W-1:0] r_base;
  logic [pHB_CNT_W-1:0]  r_hbcnt;
  logic [pHB_CNT_W-1:0]  r_hcnt;
  logic [pADDR_W-1:0]    r_zcm1;
  logic [pADDR_W-1:0]    r_cnt;
  mm_hb_value_t          r_hb;

  logic                  w_acc;
  logic                  w_cnt_last;
  logic                  w_hb_last;
  logic [pHB_ADDR_W-1:0] w_raddr;

  // A word is only consumed on an enabled clock; the source must see iclkena too.
  assign w_acc      = (r_state == ST_LOAD) && bus.ival && iclkena;
  assign w_cnt_last = (r_cnt == r_zcm1);
  assign w_hb_last  = (r_hcnt == r_hbcnt - pHB_CNT_W'(1));
  assign w_raddr    = r_base + pHB_ADDR_W'(r_hcnt);

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_state <= ST_IDLE;
    end else if (iclkena) begin
      r_state <= w_next;
    end
  end

  // r_cnt counts loaded words in LOAD and read beats in RVAL.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_base  <= '0;
      r_hbcnt <= '0;
      r_hcnt  <= '0;
      r_zcm1  <= '0;
      r_cnt   <= '0;
      r_hb    <= '0;
    end else if (iclkena) begin
      unique case (r_state)
        ST_IDLE: begin
          if (istart) begin
            r_base  <= ihb_base;
            r_hbcnt <= ihb_cnt;
            r_zcm1  <= pADDR_W'(iused_zc - hb_zc_t'(1));
            r_cnt   <= '0;
            r_hcnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.ival) r_cnt <= r_cnt + pADDR_W'(1);
        end
        ST_RSTART: begin
          r_cnt <= '0;
          r_hb  <= bus.ihb_rdat;
        end
        ST_RVAL: r_cnt  <= r_cnt + pADDR_W'(1);
        ST_RGAP: r_hcnt <= r_hcnt + pHB_CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.ordy      = 1'b0;
    bus.owrite    = 1'b0;
    bus.owstart   = 1'b0;
    bus.owdat     = '0;
    bus.ohb_raddr = '0;
    bus.oread     = 1'b0;
    bus.orstart   = 1'b0;
    bus.orval     = 1'b0;
    bus.orstrb    = '0;
    bus.orHb      = '0;
    odone         = 1'b0;
    obusy         = (r_state != ST_IDLE);

    unique case (r_state)
      ST_IDLE: begin
        if (istart) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.ordy    = 1'b1;
        bus.owrite  = w_acc;
        bus.owstart = w_acc && (r_cnt == '0);
        if (w_acc) bus.owdat = bus.idat;
        if (w_acc && w_cnt_last) w_next = (r_hbcnt == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        bus.ohb_raddr = w_raddr;
        w_next        = ST_RSTART;
      end
      ST_RSTART: begin
        // Address held so a stalled RSTART still sees the right ROM word.
        bus.ohb_raddr = w_raddr;
        bus.oread     = 1'b1;
        bus.orstart   = 1'b1;
        bus.orHb      = bus.ihb_rdat;
        w_next        = ST_RVAL;
      end
      ST_RVAL: begin
        bus.oread  = 1'b1;
        bus.orval  = 1'b1;
        bus.orstrb = strb_make(r_cnt == '0, w_cnt_last);
        bus.orHb   = r_hb;
        if (w_cnt_last) w_next = ST_RGAP;
      end
      ST_RGAP: begin
        bus.orHb = r_hb;
        w_next   = w_hb_last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        odone  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldpc_3gpp_enc_mm_seq.sv
// Bench for the multiplier sequencer: per-cycle expected trace built from the
// job description, plus a circular-shift scoreboard of the multiplier output.
module tb_ldpc_3gpp_enc_mm_seq;
  import ldpc_3gpp_enc_mm_seq_pkg::*;

  typedef struct packed {
    logic         ordy;
    logic         owrite;
    logic         owstart;
    dat_t         owdat;
    logic [7:0]   raddr;
    logic         oread;
    logic         orstart;
    logic         orval;
    strb_t        strb;
    mm_hb_value_t hb;
    logic         obusy;
    logic         odone;
  } obs_t;

  typedef struct {
    string      tag;
    logic       en;
    logic       ival;
    logic       istart;
    dat_t       idat;
    logic [7:0] base;
    logic [4:0] cnt;
    obs_t       exp;
    bit         chk_mm;
    dat_t       exp_mm;
  } cyc_t;

  logic       iclk = 1'b0;
  logic       ireset_n;
  logic       iclkena;
  logic       istart;
  hb_zc_t     iused_zc;
  logic [7:0] ihb_base;
  logic [4:0] ihb_cnt;
  logic       obusy;
  logic       odone;

  ldpc_3gpp_enc_mm_seq_if #(.pHB_ADDR_W(8)) bus ();

  ldpc_3gpp_enc_mm_seq #(
    .pADDR_W   (8),
    .pHB_ADDR_W(8),
    .pHB_CNT_W (5)
  ) dut (
    .iclk    (iclk),
    .ireset_n(ireset_n),
    .iclkena (iclkena),
    .iused_zc(iused_zc),
    .istart  (istart),
    .ihb_base(ihb_base),
    .ihb_cnt (ihb_cnt),
    .obusy   (obusy),
    .odone   (odone),
    .bus     (bus.master)
  );

  always #5 iclk = ~iclk;

  mm_hb_value_t rom [256];
  always @(posedge iclk) bus.ihb_rdat <= rom[bus.ohb_raddr];

  cyc_t         q[$];
  int           npass = 0;
  int           ntot  = 0;
  dat_t         mem [256];
  int           wp = 0;
  int           rk = 0;
  int           job_zc = 1;
  mm_hb_value_t mhb;

  function automatic obs_t sample();
    obs_t o;
    o.ordy    = bus.ordy;
    o.owrite  = bus.owrite;
    o.owstart = bus.owstart;
    o.owdat   = bus.owdat;
    o.raddr   = bus.ohb_raddr;
    o.oread   = bus.oread;
    o.orstart = bus.orstart;
    o.orval   = bus.orval;
    o.strb    = bus.orstrb;
    o.hb      = bus.orHb;
    o.obusy   = obusy;
    o.odone   = odone;
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c.tag    = "";
    c.en     = 1'b1;
    c.ival   = 1'b0;
    c.istart = 1'b0;
    c.idat   = 8'($urandom);
    c.base   = 8'($urandom);
    c.cnt    = 5'($urandom);
    c.exp    = '0;
    c.chk_mm = 1'b0;
    c.exp_mm = '0;
    return c;
  endfunction

  // Optionally precede a cycle with a clock-enable-low copy: state frozen, writes gated.
  task automatic push(input cyc_t c, input int stall_pct);
    cyc_t s;
    if (int'($urandom_range(99, 0)) < stall_pct) begin
      s             = c;
      s.tag         = {c.tag, "_hold"};
      s.en          = 1'b0;
      s.ival        = 1'($urandom_range(1, 0));
      s.istart      = 1'b0;
      s.chk_mm      = 1'b0;
      s.exp.owrite  = 1'b0;
      s.exp.owstart = 1'b0;
      s.exp.owdat   = '0;
      q.push_back(s);
    end
    q.push_back(c);
  endtask

  task automatic build_job(input int zc, input int base, input int cnt, input int stall_pct,
                           input int ival_pct, input bit seq_data, input int start_at,
                           output int first_rval);
    cyc_t c;
    dat_t d[$];
    int   acc = 0;
    int   nr  = 0;
    first_rval = -1;
    job_zc     = zc;
    c          = blank();
    c.tag      = "start";
    c.istart   = 1'b1;
    c.base     = 8'(base);
    c.cnt      = 5'(cnt);
    q.push_back(c);
    while (acc < zc) begin
      c           = blank();
      c.tag       = "load";
      c.exp.ordy  = 1'b1;
      c.exp.obusy = 1'b1;
      if (int'($urandom_range(99, 0)) < ival_pct) begin
        c.ival        = 1'b1;
        c.idat        = seq_data ? 8'(acc) : 8'($urandom);
        c.exp.owrite  = 1'b1;
        c.exp.owstart = (acc == 0);
        c.exp.owdat   = c.idat;
        d.push_back(c.idat);
        acc++;
      end
      push(c, stall_pct);
    end
    for (int e = 0; e < cnt; e++) begin
      logic [7:0]   a;
      mm_hb_value_t hb;
      int           w;
      a  = 8'(base + e);
      hb = rom[a];
      w  = int'(hb.wshift) % zc;
      c = blank(); c.tag = "fetch";
      c.exp.obusy = 1'b1; c.exp.raddr = a;
      push(c, stall_pct);
      c = blank(); c.tag = "rstart";
      c.exp.obusy = 1'b1; c.exp.oread = 1'b1; c.exp.orstart = 1'b1;
      c.exp.raddr = a; c.exp.hb = hb;
      push(c, stall_pct);
      for (int k = 0; k < zc; k++) begin
        c = blank(); c.tag = "rval";
        c.exp.obusy = 1'b1; c.exp.oread = 1'b1; c.exp.orval = 1'b1;
        c.exp.strb  = strb_make(k == 0, k == zc - 1);
        c.exp.hb    = hb;
        c.chk_mm    = 1'b1;
        c.exp_mm    = d[hb.left ? (k + w) % zc : (k + zc - w) % zc];
        if (nr == start_at) c.istart = 1'b1;
        push(c, stall_pct);
        if (first_rval < 0) first_rval = q.size() - 1;
        nr++;
      end
      c = blank(); c.tag = "rgap";
      c.exp.obusy = 1'b1; c.exp.hb = hb;
      push(c, stall_pct);
    end
    c = blank(); c.tag = "done";
    c.exp.obusy = 1'b1; c.exp.odone = 1'b1;
    push(c, stall_pct);
    c = blank(); c.tag = "idle";
    q.push_back(c);
  endtask

  task automatic step(input cyc_t c);
    obs_t o;
    dat_t mm;
    int   idx;
    int   w;
    iclkena  = c.en;
    bus.ival = c.ival;
    bus.idat = c.idat;
    istart   = c.istart;
    ihb_base = c.base;
    ihb_cnt  = c.cnt;
    @(negedge iclk);
    o = sample();
    check(c.tag, 64'(o), 64'(c.exp));
    if (c.en) begin
      if (o.owrite) begin
        if (o.owstart) wp = 0;
        mem[wp[7:0]] = o.owdat;
        wp++;
      end
      if (o.orstart) begin
        mhb = o.hb;
        rk  = 0;
      end
      if (o.orval) begin
        w   = int'(mhb.wshift) % job_zc;
        idx = mhb.left ? (rk + w) % job_zc : (rk + job_zc - w) % job_zc;
        mm  = mem[idx[7:0]];
        rk++;
        if (c.chk_mm) check({"mm_", c.tag}, 64'(mm), 64'(c.exp_mm));
      end
    end
    @(posedge iclk);
    #1;
  endtask

  task automatic run(input int n);
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      step(q.pop_front());
      k++;
    end
  endtask

  initial begin
    int   fr;
    obs_t z;
    z = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] r;
      r      = $urandom;
      rom[i] = r[12:0];
    end
    ireset_n = 1'b0;
    iclkena  = 1'b1;
    istart   = 1'b0;
    iused_zc = 8'd1;
    ihb_base = '0;
    ihb_cnt  = '0;
    bus.ival = 1'b0;
    bus.idat = '0;
    #1 check("reset", 64'(sample()), 64'(z));
    repeat (2) @(posedge iclk);
    #1 ireset_n = 1'b1;

    // Four words 0..3, left word shift of 1: multiplier reads back 1,2,3,0.
    rom[10] = '{left: 1'b1, bshift: 4'd0, wshift: 8'd1};
    iused_zc = 8'd4;
    build_job(4, 10, 1, 0, 100, 1'b1, -1, fr);
    run(-1);

    // Single-word blocks, three entries crossing the ROM address wrap.
    iused_zc = 8'd1;
    build_job(1, 254, 3, 0, 100, 1'b0, -1, fr);
    run(-1);

    // No Hb entries: load only, then done.
    iused_zc = 8'd3;
    build_job(3, 40, 0, 0, 100, 1'b0, -1, fr);
    run(-1);

    // Gappy input stream with clock-enable stalls.
    iused_zc = 8'd6;
    build_job(6, 77, 2, 15, 50, 1'b0, -1, fr);
    run(-1);

    // istart during a read slot must not disturb the running job.
    iused_zc = 8'd3;
    build_job(3, 5, 2, 0, 100, 1'b0, 1, fr);
    run(-1);

    // Asynchronous reset in the middle of a read slot.
    iused_zc = 8'd5;
    build_job(5, 100, 2, 0, 100, 1'b0, -1, fr);
    run(fr + 2);
    #2 ireset_n = 1'b0;
    #1 check("async_reset", 64'(sample()), 64'(z));
    q.delete();
    istart   = 1'b0;
    bus.ival = 1'b0;
    repeat (2) @(posedge iclk);
    #1 ireset_n = 1'b1;

    iused_zc = 8'd7;
    build_job(7, 200, 3, 10, 70, 1'b0, -1, fr);
    run(-1);

    for (int j = 0; j < 4; j++) begin
      int zc;
      zc       = int'($urandom_range(9, 1));
      iused_zc = 8'(zc);
      build_job(zc, int'($urandom_range(255, 0)), int'($urandom_range(4, 0)), 10, 75, 1'b0, -1, fr);
      run(-1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
